fetch_sequencer: RTL and testbench

// - Consumer side of the instruction ROM: reads the 24-bit word at the current pc and decides the next control action.
// - Drives the ROM's enable, jump, interrupt_jump and interrupt_clear_status controls.
// - Resolves control-flow opcodes (JMP/CALL/RET/RETI/HALT) locally.
// - Hands every other instruction to the execute unit over a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/ret_stack.sv | 58 +++++
 rtl/fetch_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, opcode encodings and FSM state type for the
// instruction fetch sequencer and its return-address stack.
package fetch_pkg;

  localparam int unsigned PC_W    = 11;
  localparam int unsigned INSTR_W = 24;
  localparam int unsigned ROM_LEN = 1024;

  // Control-flow opcodes resolved inside the sequencer; everything else is
  // handed to the execute unit.
  localparam logic [7:0] OP_JMP  = 8'h20;
  localparam logic [7:0] OP_CALL = 8'h21;
  localparam logic [7:0] OP_RET  = 8'h22;
  localparam logic [7:0] OP_RETI = 8'h23;
  localparam logic [7:0] OP_HALT = 8'h24;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  function automatic logic [7:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[23:16];
  endfunction

  function automatic logic [PC_W-1:0] target_of(input logic [INSTR_W-1:0] word);
    return word[PC_W-1:0];
  endfunction

endpackage

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses for CALL/RET. Push is ignored when
// full and pop is ignored when empty; the caller reports those cases.
module ret_stack
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            full,
  output logic            empty
);

  localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned       IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [PC_W-1:0]  mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] top_idx, wr_idx;

  assign full     = (cnt_q == CNT_FULL);
  assign empty    = (cnt_q == '0);
  assign top_idx  = IDX_W'(cnt_q - 1'b1);
  assign wr_idx   = IDX_W'(cnt_q);
  assign top_data = mem_q[top_idx];

  // Next-state of the stack storage and occupancy count.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push && !full) begin
      mem_d[wr_idx] = push_data;
      cnt_d         = cnt_q + 1'b1;
    end else if (pop && !empty) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Stack registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: consumes the ROM word at the current pc, resolves
// JMP/CALL/RET/RETI/HALT locally and offers all other words to the execute
// unit over a valid/ready handshake. Build option FETCH_CALL_STACK_EN adds the
// return-address stack; without it CALL and RET are ordinary instructions.
module fetch_sequencer #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned ROM_LEN     = fetch_pkg::ROM_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [fetch_pkg::INSTR_W-1:0] rom_data,
  input  logic [fetch_pkg::PC_W-1:0]    rom_pc,
  output logic                         rom_enable,
  output logic                         rom_jump_enable,
  output logic [fetch_pkg::PC_W-1:0]    rom_jump_data,
  output logic                         rom_interrupt_jump,
  output logic                         rom_interrupt_clear,
  output logic                         instr_valid,
  output logic [fetch_pkg::INSTR_W-1:0] instr_data,
  output logic [fetch_pkg::PC_W-1:0]    instr_pc,
  input  logic                         instr_ready,
  input  logic                         irq_req,
  output logic                         irq_ack,
  output logic                         in_isr,
  output logic                         halted,
  output logic                         stack_err,
  output logic                         illegal_target
);

  import fetch_pkg::*;

  localparam logic [PC_W:0] ROM_END = (PC_W + 1)'(ROM_LEN);

  state_e          state_q, state_d;
  logic            in_isr_q, in_isr_d;
  logic            ill_q, ill_d;
  logic [7:0]      opcode;
  logic [PC_W-1:0] target;
  logic            target_ok;
  logic            unused_word;

  assign opcode      = opcode_of(rom_data);
  assign target      = target_of(rom_data);
  assign target_ok   = ({1'b0, target} < ROM_END);
  assign unused_word = ^rom_data[15:11];

`ifdef FETCH_CALL_STACK_EN
  logic            serr_q, serr_d;
  logic            stk_push, stk_pop, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top, ret_addr;

  assign ret_addr = rom_pc + 1'b1;

  ret_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_data(ret_addr),
    .top_data (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  assign stack_err = serr_q;
`else
  logic [31:0] unused_depth;
  assign unused_depth = STACK_DEPTH;
  assign stack_err    = 1'b0;
`endif

  // Pass-through of the current word; forced to zero while reset is held.
  assign instr_data     = rst_n ? rom_data : '0;
  assign instr_pc       = rst_n ? rom_pc : '0;
  assign in_isr         = in_isr_q;
  assign illegal_target = ill_q;
  assign halted         = (state_q == ST_HALT);

  // Decode: ROM strobes, handshake and next state from state and current word.
  // Strobes are gated by rst_n so every output drops the moment reset asserts.
  always_comb begin
    state_d             = state_q;
    in_isr_d            = in_isr_q;
    ill_d               = ill_q;
    rom_enable          = 1'b0;
    rom_jump_enable     = 1'b0;
    rom_jump_data       = '0;
    rom_interrupt_jump  = 1'b0;
    rom_interrupt_clear = 1'b0;
    instr_valid         = 1'b0;
    irq_ack             = 1'b0;
`ifdef FETCH_CALL_STACK_EN
    serr_d   = serr_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`endif
    if (rst_n) begin
      unique case (state_q)
        ST_SETTLE: state_d = ST_FETCH;
        ST_FETCH, ST_HALT: begin
          // An interrupt leaves HALT too; the ROM saves the HALT pc, so the
          // ISR's RETI lands back on the HALT word.
          if (irq_req && !in_isr_q) begin
            rom_interrupt_jump = 1'b1;
            irq_ack            = 1'b1;
            in_isr_d           = 1'b1;
            state_d            = ST_SETTLE;
          end else if (state_q == ST_FETCH) begin
            if (opcode == OP_JMP) begin
              if (target_ok) begin
                rom_jump_enable = 1'b1;
                rom_jump_data   = target;
                state_d         = ST_SETTLE;
              end else begin
                ill_d      = 1'b1;
                rom_enable = 1'b1;
              end
            end
`ifdef FETCH_CALL_STACK_EN
            else if (opcode == OP_CALL) begin
              if (target_ok) begin
                rom_jump_enable = 1'b1;
                rom_jump_data   = target;
                state_d         = ST_SETTLE;
                if (stk_full) serr_d = 1'b1;
                else          stk_push = 1'b1;
              end else begin
                ill_d      = 1'b1;
                rom_enable = 1'b1;
              end
            end else if (opcode == OP_RET) begin
              if (stk_empty) begin
                serr_d     = 1'b1;
                rom_enable = 1'b1;
              end else begin
                stk_pop         = 1'b1;
                rom_jump_enable = 1'b1;
                rom_jump_data   = stk_top;
                state_d         = ST_SETTLE;
              end
            end
`endif
            else if (opcode == OP_RETI) begin
              if (in_isr_q) begin
                rom_interrupt_clear = 1'b1;
                in_isr_d            = 1'b0;
                state_d             = ST_SETTLE;
              end else begin
                rom_enable = 1'b1;
              end
            end else if (opcode == OP_HALT) begin
              state_d = ST_HALT;
            end else begin
              instr_valid = 1'b1;
              rom_enable  = instr_ready;
            end
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // FSM state and sticky status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      in_isr_q <= 1'b0;
      ill_q    <= 1'b0;
`ifdef FETCH_CALL_STACK_EN
      serr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      in_isr_q <= in_isr_d;
      ill_q    <= ill_d;
`ifdef FETCH_CALL_STACK_EN
      serr_q   <= serr_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a behavioural ROM drives rom_data/rom_pc, an
// architectural model predicts every cycle in which the sequencer shows
// activity, and a monitor compares DUT activity against the predicted queue.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned RLEN    = 1024;
  localparam logic [10:0] ISR_VEC = 11'h040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] rom_data;
  logic [10:0] rom_pc, saved_pc;
  logic        rom_enable, rom_jump_enable, rom_interrupt_jump, rom_interrupt_clear;
  logic [10:0] rom_jump_data;
  logic        instr_valid, instr_ready = 1'b0;
  logic [23:0] instr_data;
  logic [10:0] instr_pc;
  logic        irq_req = 1'b0, irq_ack, in_isr, halted, stack_err, illegal_target;

  always #5 clk = ~clk;

  fetch_sequencer #(.STACK_DEPTH(DEPTH), .ROM_LEN(RLEN)) dut (
    .clk(clk), .rst_n(rst_n), .rom_data(rom_data), .rom_pc(rom_pc),
    .rom_enable(rom_enable), .rom_jump_enable(rom_jump_enable),
    .rom_jump_data(rom_jump_data), .rom_interrupt_jump(rom_interrupt_jump),
    .rom_interrupt_clear(rom_interrupt_clear), .instr_valid(instr_valid),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .irq_req(irq_req), .irq_ack(irq_ack), .in_isr(in_isr), .halted(halted),
    .stack_err(stack_err), .illegal_target(illegal_target)
  );

  // Behavioural instruction ROM with one-level interrupt save register.
  logic [23:0] prog [2048];
  assign rom_data = prog[rom_pc];

  function automatic logic [10:0] adv(input logic [10:0] p);
    return (p >= 11'(RLEN - 1)) ? 11'(RLEN - 1) : p + 11'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_pc   <= '0;
      saved_pc <= '0;
    end else if (rom_interrupt_jump) begin
      saved_pc <= rom_pc;
      rom_pc   <= ISR_VEC;
    end else if (rom_interrupt_clear) rom_pc <= saved_pc;
    else if (rom_jump_enable) rom_pc <= rom_jump_data;
    else if (rom_enable) rom_pc <= adv(rom_pc);
  end

  typedef struct packed {
    logic        en;
    logic        jmp;
    logic [10:0] jd;
    logic        ij;
    logic        ic;
    logic        valid;
    logic [10:0] ipc;
    logic [23:0] idata;
    logic        ack;
    logic        isr;
    logic        hlt;
    logic        serr;
    logic        ill;
  } obs_t;

  obs_t exp_q[$];
  int   exp_cyc_q[$];
  int   n_vec = 0, n_fail = 0, cyc = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Architectural reference: pc, return stack as a queue, ISR flag.
  logic [10:0] m_pc, m_saved;
  logic [10:0] m_stk[$];
  bit          m_isr, m_hlt, m_bub, m_serr, m_ill;

  task automatic model_reset();
    m_pc = '0; m_saved = '0; m_stk = {};
    m_isr = 0; m_hlt = 0; m_bub = 0; m_serr = 0; m_ill = 0;
    exp_q = {}; exp_cyc_q = {};
    cyc = 0;
  endtask

  task automatic model_step(input bit irq, input bit rdy);
    obs_t        r;
    logic [23:0] w;
    logic [7:0]  op;
    logic [10:0] t;
    bit          legal;
    r = '0;
    r.isr = m_isr; r.hlt = m_hlt; r.serr = m_serr; r.ill = m_ill;
    if (m_bub) begin
      m_bub = 0;
      return;
    end
    w = prog[m_pc]; op = w[23:16]; t = w[10:0];
    legal = ({1'b0, t} < 12'(RLEN));
    if (irq && !m_isr) begin
      r.ij = 1; r.ack = 1;
      m_isr = 1; m_saved = m_pc; m_pc = ISR_VEC; m_hlt = 0; m_bub = 1;
    end else if (m_hlt) begin
      // parked on HALT
    end else if (op == OP_JMP && legal) begin
      r.jmp = 1; r.jd = t; m_pc = t; m_bub = 1;
    end else if (op == OP_JMP) begin
      m_ill = 1; r.en = 1; m_pc = adv(m_pc);
`ifdef FETCH_CALL_STACK_EN
    end else if (op == OP_CALL && legal) begin
      if (m_stk.size() == DEPTH) m_serr = 1;
      else m_stk.push_back(m_pc + 11'd1);
      r.jmp = 1; r.jd = t; m_pc = t; m_bub = 1;
    end else if (op == OP_CALL) begin
      m_ill = 1; r.en = 1; m_pc = adv(m_pc);
    end else if (op == OP_RET && m_stk.size() == 0) begin
      m_serr = 1; r.en = 1; m_pc = adv(m_pc);
    end else if (op == OP_RET) begin
      m_pc = m_stk.pop_back(); r.jmp = 1; r.jd = m_pc; m_bub = 1;
`endif
    end else if (op == OP_RETI && m_isr) begin
      r.ic = 1; m_isr = 0; m_pc = m_saved; m_bub = 1;
    end else if (op == OP_RETI) begin
      r.en = 1; m_pc = adv(m_pc);
    end else if (op == OP_HALT) begin
      m_hlt = 1;
    end else begin
      r.valid = 1; r.ipc = m_pc; r.idata = w;
      if (rdy) begin
        r.en = 1; m_pc = adv(m_pc);
      end
    end
    if (r.en || r.jmp || r.ij || r.ic || r.valid || r.hlt) begin
      exp_q.push_back(r);
      exp_cyc_q.push_back(cyc);
    end
  endtask

  // Monitor: every cycle the DUT shows activity, pop and compare.
  initial begin
    obs_t a, e;
    int   ecyc;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        a = '0;
        a.en = rom_enable; a.jmp = rom_jump_enable;
        a.jd = rom_jump_enable ? rom_jump_data : '0;
        a.ij = rom_interrupt_jump; a.ic = rom_interrupt_clear; a.valid = instr_valid;
        a.ipc = instr_valid ? instr_pc : '0;
        a.idata = instr_valid ? instr_data : '0;
        a.ack = irq_ack; a.isr = in_isr; a.hlt = halted;
        a.serr = stack_err; a.ill = illegal_target;
        if (a.en || a.jmp || a.ij || a.ic || a.valid || a.hlt) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(a), 64'(0));
          end else begin
            e = exp_q.pop_front();
            ecyc = exp_cyc_q.pop_front();
            check("event_cycle", 64'(cyc), 64'(ecyc));
            check("outputs", 64'(a), 64'(e));
          end
        end
      end
    end
  end

  function automatic logic [55:0] all_outputs();
    return {rom_enable, rom_jump_enable, rom_jump_data, rom_interrupt_jump,
            rom_interrupt_clear, instr_valid, instr_data, instr_pc, irq_ack,
            in_isr, halted, stack_err, illegal_target};
  endfunction

  function automatic logic [23:0] mk(input logic [7:0] op, input logic [10:0] t);
    return {op, 5'd0, t};
  endfunction

  function automatic logic [23:0] rand_word();
    int unsigned r;
    logic [7:0]  op;
    logic [10:0] t;
    r = $urandom_range(0, 63);
    t = ($urandom_range(0, 15) == 0) ? 11'($urandom_range(RLEN, 2047))
                                     : 11'($urandom_range(0, 127));
    op = 8'($urandom_range(0, 255));
    if (op >= OP_JMP && op <= OP_HALT) op = op ^ 8'h80;
    if (r < 6) op = OP_JMP;
    else if (r < 12) op = OP_CALL;
    else if (r < 18) op = OP_RET;
    else if (r < 22) op = OP_RETI;
    else if (r < 23) op = OP_HALT;
    return {op, 5'($urandom_range(0, 31)), t};
  endfunction

  // kind 0: linear/call/jump flow, 1: nested calls, 2: random, 3: reset probe
  task automatic load_prog(input int kind);
    for (int i = 0; i < 2048; i++) prog[i] = mk(8'h01, 11'(i));
    case (kind)
      0: begin
        prog[3]     = mk(OP_JMP, 11'h010);
        prog[16]    = mk(OP_CALL, 11'h100);
        prog[17]    = mk(OP_JMP, 11'h7FF);
        prog[19]    = mk(OP_JMP, 11'h013);
        prog[65]    = mk(OP_RETI, 11'h000);
        prog[257]   = mk(OP_RET, 11'h000);
      end
      1: begin
        for (int i = 0; i < 9; i++) prog[i] = mk(OP_CALL, 11'(i + 1));
        prog[9] = mk(OP_RET, 11'h000);
      end
      2: begin
        for (int i = 0; i < int'(RLEN) - 1; i++) prog[i] = rand_word();
      end
      default: begin
        prog[0] = mk(OP_RET, 11'h000);
        prog[1] = mk(OP_JMP, 11'h7FF);
      end
    endcase
  endtask

  task automatic start_seg(input int kind);
    @(negedge clk);
    rst_n = 1'b0; irq_req = 1'b0; instr_ready = 1'b0;
    load_prog(kind);
    #1 check("reset_outputs", 64'(all_outputs()), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic step(input bit irq, input bit rdy);
    irq_req = irq;
    instr_ready = rdy;
    cyc++;
    model_step(irq, rdy);
  endtask

  task automatic run_cycles(input int n, input bit use_irq, input bit always_ready);
    bit irq, rdy;
    for (int c = 0; c < n; c++) begin
      irq = use_irq && ($urandom_range(0, 15) == 0);
      rdy = always_ready || ($urandom_range(0, 3) != 0);
      step(irq, rdy);
      @(negedge clk);
    end
  endtask

  task automatic end_seg();
    mon_en = 1'b0;
    check("queue_drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    start_seg(0); run_cycles(12, 1'b0, 1'b1); run_cycles(300, 1'b1, 1'b0); end_seg();
    start_seg(1); run_cycles(200, 1'b0, 1'b0); end_seg();
    for (int s = 0; s < 4; s++) begin
      start_seg(2); run_cycles(1500, 1'b1, 1'b0); end_seg();
    end
    // Reset asserted while the sequencer sits in the post-interrupt bubble.
    start_seg(3);
    step(1'b0, 1'b1); @(negedge clk);
    step(1'b0, 1'b1); @(negedge clk);
    step(1'b1, 1'b1); @(negedge clk);
    step(1'b1, 1'b1);
    #1 check("pre_reset_flags", 64'({in_isr, illegal_target, stack_err}),
             64'({m_isr, m_ill, m_serr}));
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1 check("reset_in_settle", 64'(all_outputs()), 64'(0));
    check("queue_drain", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
